// File: rtl/uart_core_param_if.sv
// Host-side handshake bundle for uart_core_param: TX request/accept and RX delivery/status.
interface uart_core_param_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_frame_err;
  logic              rx_parity_err;
  logic              rx_overrun;
  logic              rx_break;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_break
  );
  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_parity_err, rx_overrun, rx_break
  );
endinterface

// File: rtl/uart_core_param.sv
// Full-duplex UART: runtime divisor/parity/stop bits, OVS-oversampled RX with glitch rejection.
// Define UART_BREAK_DETECT_EN to report all-zero frames as rx_break instead of data.
module uart_core_param #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_parity,
  input  logic             cfg_stop2,
  output logic             tx,
  input  logic             rx,
  uart_core_param_if.slave bus
);
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVS / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
`ifdef UART_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  // ---------------- oversample tick ----------------
  logic [DIV_W-1:0] div_cnt, div_last;
  logic             tick;

  assign div_last = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  // >= keeps the counter bounded if baud_div shrinks mid-count
  assign tick     = (div_cnt >= div_last);

  always_ff @(posedge clk or posedge rst)
    if (rst) div_cnt <= '0;
    else     div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP1, TX_STOP2} tx_st_t;
  tx_st_t            tx_st, tx_st_n;
  logic [TW-1:0]     tx_tc, tx_tc_n;
  logic [BW-1:0]     tx_bc, tx_bc_n;
  logic [DATA_W-1:0] tx_sh, tx_sh_n;
  logic              tx_pen, tx_pen_n, tx_pbit, tx_pbit_n, tx_s2, tx_s2_n, tx_n;
  logic              tx_bit_end;

  assign tx_bit_end = tick && (tx_tc == T_LAST);

  always_comb begin
    tx_st_n   = tx_st;
    tx_tc_n   = tx_tc;
    tx_bc_n   = tx_bc;
    tx_sh_n   = tx_sh;
    tx_pen_n  = tx_pen;
    tx_pbit_n = tx_pbit;
    tx_s2_n   = tx_s2;
    tx_n      = 1'b1;
    if (tick) tx_tc_n = tx_bit_end ? '0 : tx_tc + TW'(1);
    case (tx_st)
      TX_IDLE: begin
        tx_tc_n = '0;
        tx_bc_n = '0;
        if (bus.tx_valid) begin
          tx_st_n   = TX_START;
          tx_sh_n   = bus.tx_data;
          tx_pen_n  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          tx_pbit_n = (cfg_parity == 2'b10) ? ~^bus.tx_data : ^bus.tx_data;
          tx_s2_n   = cfg_stop2;
        end
      end
      TX_START: if (tx_bit_end) tx_st_n = TX_DATA;
      TX_DATA: if (tx_bit_end) begin
        tx_sh_n = tx_sh >> 1;
        tx_bc_n = tx_bc + BW'(1);
        if (tx_bc == B_LAST) tx_st_n = tx_pen ? TX_PAR : TX_STOP1;
      end
      TX_PAR:   if (tx_bit_end) tx_st_n = TX_STOP1;
      TX_STOP1: if (tx_bit_end) tx_st_n = tx_s2 ? TX_STOP2 : TX_IDLE;
      TX_STOP2: if (tx_bit_end) tx_st_n = TX_IDLE;
      default:  tx_st_n = TX_IDLE;
    endcase
    // line level follows the state being entered so tx is a clean flop output
    case (tx_st_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = tx_sh_n[0];
      TX_PAR:   tx_n = tx_pbit_n;
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st   <= TX_IDLE;
      tx_tc   <= '0;
      tx_bc   <= '0;
      tx_sh   <= '0;
      tx_pen  <= 1'b0;
      tx_pbit <= 1'b0;
      tx_s2   <= 1'b0;
      tx      <= 1'b1;
    end else begin
      tx_st   <= tx_st_n;
      tx_tc   <= tx_tc_n;
      tx_bc   <= tx_bc_n;
      tx_sh   <= tx_sh_n;
      tx_pen  <= tx_pen_n;
      tx_pbit <= tx_pbit_n;
      tx_s2   <= tx_s2_n;
      tx      <= tx_n;
    end

  assign bus.tx_ready = (tx_st == TX_IDLE);
  assign bus.tx_busy  = (tx_st != TX_IDLE);

  // ---------------- receiver ----------------
  logic rx_m, rx_s, rx_d;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK} rx_st_t;
  rx_st_t            rx_st, rx_st_n;
  logic [TW-1:0]     rx_tc, rx_tc_n;
  logic [BW-1:0]     rx_bc, rx_bc_n;
  logic [DATA_W-1:0] rx_sh, rx_sh_n;
  logic              rx_pen, rx_pen_n, rx_odd, rx_odd_n, rx_pbit, rx_pbit_n;
  logic              rx_samp, rx_done, rx_ferr_n, rx_perr_n, rx_brk_n, rx_zero;

  assign rx_samp = tick && (rx_tc == T_LAST);
  assign rx_zero = !rx_s && (rx_sh == '0) && !(rx_pen && rx_pbit);

  always_comb begin
    rx_st_n   = rx_st;
    rx_tc_n   = rx_tc;
    rx_bc_n   = rx_bc;
    rx_sh_n   = rx_sh;
    rx_pen_n  = rx_pen;
    rx_odd_n  = rx_odd;
    rx_pbit_n = rx_pbit;
    rx_done   = 1'b0;
    rx_ferr_n = 1'b0;
    rx_perr_n = 1'b0;
    rx_brk_n  = 1'b0;
    if (tick) rx_tc_n = rx_samp ? '0 : rx_tc + TW'(1);
    case (rx_st)
      RX_IDLE: begin
        rx_tc_n   = '0;
        rx_bc_n   = '0;
        rx_pbit_n = 1'b0;
        if (rx_d && !rx_s) begin
          rx_st_n  = RX_START;
          rx_pen_n = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          rx_odd_n = (cfg_parity == 2'b10);
        end
      end
      // half a bit in: still low means a real start bit, and aligns later samples to bit centres
      RX_START: if (tick && rx_tc == T_HALF) begin
        rx_tc_n = '0;
        rx_st_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_samp) begin
        rx_sh_n = {rx_s, rx_sh[DATA_W-1:1]};
        rx_bc_n = rx_bc + BW'(1);
        if (rx_bc == B_LAST) rx_st_n = rx_pen ? RX_PAR : RX_STOP;
      end
      RX_PAR: if (rx_samp) begin
        rx_pbit_n = rx_s;
        rx_st_n   = RX_STOP;
      end
      RX_STOP: if (rx_samp) begin
        if (BRK_EN && rx_zero) begin
          rx_brk_n = 1'b1;
          rx_st_n  = RX_BRK;
        end else begin
          rx_done   = 1'b1;
          rx_ferr_n = !rx_s;
          rx_perr_n = rx_pen && (rx_pbit ^ (^rx_sh) ^ rx_odd);
          rx_st_n   = RX_IDLE;
        end
      end
      RX_BRK:  if (rx_s) rx_st_n = RX_IDLE;
      default: rx_st_n = RX_IDLE;
    endcase
  end

  logic [DATA_W-1:0] rx_data_q;
  logic              rx_vld_q, rx_ferr_q, rx_perr_q, rx_ov_q, rx_brk_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_st     <= RX_IDLE;
      rx_tc     <= '0;
      rx_bc     <= '0;
      rx_sh     <= '0;
      rx_pen    <= 1'b0;
      rx_odd    <= 1'b0;
      rx_pbit   <= 1'b0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_ov_q   <= 1'b0;
      rx_brk_q  <= 1'b0;
    end else begin
      rx_st    <= rx_st_n;
      rx_tc    <= rx_tc_n;
      rx_bc    <= rx_bc_n;
      rx_sh    <= rx_sh_n;
      rx_pen   <= rx_pen_n;
      rx_odd   <= rx_odd_n;
      rx_pbit  <= rx_pbit_n;
      rx_ov_q  <= 1'b0;
      rx_brk_q <= rx_brk_n;
      // a completion coinciding with a handshake replaces the held word
      if (rx_done && rx_vld_q && !bus.rx_ready) begin
        rx_ov_q <= 1'b1;
      end else if (rx_done) begin
        rx_data_q <= rx_sh;
        rx_ferr_q <= rx_ferr_n;
        rx_perr_q <= rx_perr_n;
        rx_vld_q  <= 1'b1;
      end else if (rx_vld_q && bus.rx_ready) begin
        rx_vld_q <= 1'b0;
      end
    end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_vld_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_overrun    = rx_ov_q;
  assign bus.rx_break      = rx_brk_q;
endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param at DATA_W=8, OVS=16, baud_div=4 (64 clk per bit).
module tb_uart_core_param;
  localparam int DATA_W = 8;
  localparam int OVS    = 16;
  localparam int DIV_W  = 16;
  localparam int BIT    = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] baud_div = 16'd4;
  logic [1:0]       cfg_parity = 2'b00;
  logic             cfg_stop2 = 1'b0;
  logic             tx;
  logic             rx;
  logic             rx_drv = 1'b1;
  logic             loop = 1'b0;
  int               n_chk = 0, n_pass = 0, ov_cnt = 0, brk_cnt = 0;

  assign rx = loop ? tx : rx_drv;

  uart_core_param_if #(.DATA_W(DATA_W)) bus ();

  uart_core_param #(.DATA_W(DATA_W), .OVS(OVS), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .cfg_parity(cfg_parity),
    .cfg_stop2(cfg_stop2), .tx(tx), .rx(rx), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_overrun) ov_cnt <= ov_cnt + 1;
    if (bus.rx_break)   brk_cnt <= brk_cnt + 1;
  end

  task automatic send_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input bit pen, input bit pbit, input bit stopv);
    rx_drv = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (BIT) @(negedge clk);
    end
    if (pen) begin
      rx_drv = pbit;
      repeat (BIT) @(negedge clk);
    end
    rx_drv = stopv;
    repeat (BIT) @(negedge clk);
    rx_drv = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_rx(output bit ok);
    int n = 0;
    while (!bus.rx_valid && n < 1500) begin
      @(negedge clk);
      n++;
    end
    ok = bus.rx_valid;
  endtask

  task automatic consume();
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if ({tx, bus.tx_ready, bus.tx_busy, bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun, bus.rx_break} !== 8'b1100_0000)
      $display("FAIL reset_flags: got %b want 11000000", {tx, bus.tx_ready, bus.tx_busy, bus.rx_valid, bus.rx_frame_err, bus.rx_parity_err, bus.rx_overrun, bus.rx_break}); else n_pass++;
    n_chk++; if (bus.rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); else n_pass++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++; if ({tx, bus.tx_ready} !== 2'b11) $display("FAIL idle_after_reset: got %b want 11", {tx, bus.tx_ready}); else n_pass++;
  endtask

  // 0xA5, no parity, 1 stop: bit centres sampled half a bit past each boundary
  task automatic test_tx_frame();
    logic [9:0] exp;
    int cyc;
    exp = {1'b1, 8'hA5, 1'b0};
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    send_tx(8'hA5);
    @(negedge clk);
    cyc = 0;
    n_chk++; if ({tx, bus.tx_ready, bus.tx_busy} !== 3'b001) $display("FAIL tx_accept: got %b want 001", {tx, bus.tx_ready, bus.tx_busy}); else n_pass++;
    repeat (32) @(negedge clk);
    cyc += 32;
    for (int i = 0; i < 10; i++) begin
      n_chk++; if (tx !== exp[i]) $display("FAIL tx_bit%0d: got %b want %b", i, tx, exp[i]); else n_pass++;
      if (i < 9) begin
        repeat (BIT) @(negedge clk);
        cyc += BIT;
      end
    end
    while (!bus.tx_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    // the free-running tick puts the rise within one tick period ending at 640
    n_chk++; if (cyc < 637 || cyc > 640) $display("FAIL tx_ready_time: got %0d want 637..640", cyc); else n_pass++;
  endtask

  task automatic test_loopback_parity();
    int cyc, nb;
    bit ok;
    loop = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cfg_parity = (p == 0) ? 2'b01 : 2'b10;
      cfg_stop2  = (p == 1);
      nb = 11 + p;
      send_tx(8'h3C);
      @(negedge clk);
      cyc = 0;
      repeat (32 + 9 * BIT) @(negedge clk);
      cyc += 32 + 9 * BIT;
      n_chk++; if (tx !== (p == 1)) $display("FAIL lb_parity_bit%0d: got %b want %0d", p, tx, p); else n_pass++;
      while (!bus.rx_valid && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      ok = bus.rx_valid;
      n_chk++; if (!ok) $display("FAIL lb_rx_valid%0d: got 0 want 1", p); else n_pass++;
      n_chk++; if ({bus.rx_data, bus.rx_frame_err, bus.rx_parity_err} !== {8'h3C, 2'b00})
        $display("FAIL lb_rx%0d: got %h/%b%b want 3c/00", p, bus.rx_data, bus.rx_frame_err, bus.rx_parity_err); else n_pass++;
      consume();
      cyc++;
      n_chk++; if (bus.rx_valid !== 1'b0) $display("FAIL lb_consume%0d: got %b want 0", p, bus.rx_valid); else n_pass++;
      while (!bus.tx_ready && cyc < 2000) begin
        @(negedge clk);
        cyc++;
      end
      n_chk++; if (cyc < nb * BIT - 3 || cyc > nb * BIT) $display("FAIL lb_tx_ready%0d: got %0d want %0d..%0d", p, cyc, nb * BIT - 3, nb * BIT); else n_pass++;
    end
    loop = 1'b0;
  endtask

  task automatic test_rx_errors();
    bit ok;
    cfg_parity = 2'b01;
    send_rx(8'h55, 1'b1, 1'b1, 1'b1);
    wait_rx(ok);
    n_chk++; if ({ok, bus.rx_data, bus.rx_frame_err, bus.rx_parity_err} !== {1'b1, 8'h55, 2'b01})
      $display("FAIL rx_parity_err: got %b/%h/%b%b want 1/55/01", ok, bus.rx_data, bus.rx_frame_err, bus.rx_parity_err); else n_pass++;
    consume();
    send_rx(8'h55, 1'b1, 1'b0, 1'b0);
    wait_rx(ok);
    n_chk++; if ({ok, bus.rx_data, bus.rx_frame_err, bus.rx_parity_err} !== {1'b1, 8'h55, 2'b10})
      $display("FAIL rx_frame_err: got %b/%h/%b%b want 1/55/10", ok, bus.rx_data, bus.rx_frame_err, bus.rx_parity_err); else n_pass++;
    consume();
    cfg_parity = 2'b00;
  endtask

  // frames are 704 clk apart (multiple of the tick period), so completion offsets repeat exactly
  task automatic test_overrun();
    int t = 0, d0;
    d0 = ov_cnt;
    fork
      send_rx(8'h11, 1'b0, 1'b0, 1'b1);
      begin
        while (!bus.rx_valid && t < BIT * 11) begin
          @(negedge clk);
          t++;
        end
      end
    join
    n_chk++; if (bus.rx_valid !== 1'b1) $display("FAIL ov_first_valid: got %b want 1", bus.rx_valid); else n_pass++;
    send_rx(8'h22, 1'b0, 1'b0, 1'b1);
    n_chk++; if (ov_cnt - d0 !== 1) $display("FAIL ov_pulses: got %0d want 1", ov_cnt - d0); else n_pass++;
    n_chk++; if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h11}) $display("FAIL ov_kept: got %b/%h want 1/11", bus.rx_valid, bus.rx_data); else n_pass++;
    d0 = ov_cnt;
    fork
      send_rx(8'h22, 1'b0, 1'b0, 1'b1);
      begin
        repeat (t - 1) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    n_chk++; if ({bus.rx_valid, bus.rx_data} !== {1'b1, 8'h22}) $display("FAIL same_cycle_load: got %b/%h want 1/22", bus.rx_valid, bus.rx_data); else n_pass++;
    n_chk++; if (ov_cnt - d0 !== 0) $display("FAIL same_cycle_overrun: got %0d want 0", ov_cnt - d0); else n_pass++;
    consume();
  endtask

  task automatic test_glitch_reset();
    int seen = 0;
    rx_drv = 1'b0;
    repeat (24) @(negedge clk);
    rx_drv = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (bus.rx_valid) seen++;
    end
    n_chk++; if (seen !== 0) $display("FAIL glitch_reject: got %0d valid cycles want 0", seen); else n_pass++;
    send_tx(8'hF0);
    repeat (200) @(negedge clk);
    n_chk++; if ({tx, bus.tx_busy} !== 2'b01) $display("FAIL mid_tx: got %b want 01", {tx, bus.tx_busy}); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if ({tx, bus.tx_ready, bus.tx_busy} !== 3'b110) $display("FAIL reset_mid_tx: got %b want 110", {tx, bus.tx_ready, bus.tx_busy}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_break();
    int seen = 0, b0;
    logic [7:0] d = 8'hFF;
    logic fe = 1'b0;
    b0 = brk_cnt;
    cfg_parity = 2'b00;
    rx_drv = 1'b0;
    repeat (12 * BIT) begin
      @(negedge clk);
      if (bus.rx_valid && seen == 0) begin
        d  = bus.rx_data;
        fe = bus.rx_frame_err;
      end
      if (bus.rx_valid) seen++;
    end
    rx_drv = 1'b1;
    repeat (2 * BIT) @(negedge clk);
`ifdef UART_BREAK_DETECT_EN
    n_chk++; if (brk_cnt - b0 !== 1) $display("FAIL break_pulse: got %0d want 1", brk_cnt - b0); else n_pass++;
    n_chk++; if (seen !== 0) $display("FAIL break_no_valid: got %0d want 0", seen); else n_pass++;
`else
    n_chk++; if (brk_cnt - b0 !== 0) $display("FAIL break_tied: got %0d want 0", brk_cnt - b0); else n_pass++;
    n_chk++; if ({seen != 0, d, fe} !== {1'b1, 8'h00, 1'b1}) $display("FAIL break_as_data: got %b/%h/%b want 1/00/1", seen != 0, d, fe); else n_pass++;
    consume();
`endif
  endtask

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    test_reset();
    test_tx_frame();
    test_loopback_parity();
    test_rx_errors();
    test_overrun();
    test_glitch_reset();
    test_break();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end
endmodule
